// File: rtl/serial_logic_processor.sv
// Bit-serial logic processor: two operand registers shifted LSB-first through a
// selectable bitwise function and routing network, with an optional multi-pass repeat.
module serial_logic_processor #(
   parameter int WIDTH  = 8,
   parameter int PASS_W = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              LoadA,
   input  logic              LoadB,
   input  logic              Execute,
   input  logic [WIDTH-1:0]  Din,
   input  logic [2:0]        F,
   input  logic [1:0]        R,
   input  logic [PASS_W-1:0] Passes,
   output logic [WIDTH-1:0]  A,
   output logic [WIDTH-1:0]  B,
   output logic              Busy,
   output logic              Done
);

   // Sized for the longest operation so the count never wraps.
   localparam int CNT_W = $clog2(WIDTH * (2 ** PASS_W));

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t              state_reg, state_next;
   logic [WIDTH-1:0]    a_reg, a_next;
   logic [WIDTH-1:0]    b_reg, b_next;
   logic [2:0]          f_reg, f_next;
   logic [1:0]          r_reg, r_next;
   logic [PASS_W-1:0]   passes_reg, passes_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic                busy_reg, busy_next;
   logic                done_reg, done_next;

   logic bit_a, bit_b, fn_bit, route_a, route_b, last_shift;

   // Per-bit function and routing of the bit pair leaving the LSBs.
   always_comb begin
      bit_a   = a_reg[0];
      bit_b   = b_reg[0];
      fn_bit  = 1'b0;
      route_a = bit_a;
      route_b = bit_b;
      case (f_reg)
         3'b000:  fn_bit = bit_a & bit_b;
         3'b001:  fn_bit = bit_a | bit_b;
         3'b010:  fn_bit = bit_a ^ bit_b;
         3'b011:  fn_bit = 1'b1;
         3'b100:  fn_bit = ~(bit_a & bit_b);
         3'b101:  fn_bit = ~(bit_a | bit_b);
         3'b110:  fn_bit = ~(bit_a ^ bit_b);
         default: fn_bit = 1'b0;
      endcase
      case (r_reg)
         2'b00: begin route_a = bit_a;  route_b = bit_b;  end
         2'b01: begin route_a = bit_a;  route_b = fn_bit; end
         2'b10: begin route_a = fn_bit; route_b = bit_b;  end
         default: begin route_a = bit_b; route_b = bit_a; end
      endcase
   end

   assign last_shift = (cnt_reg == CNT_W'(WIDTH * (int'(passes_reg) + 1) - 1));

   always_comb begin
      state_next  = state_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      f_next      = f_reg;
      r_next      = r_reg;
      passes_next = passes_reg;
      cnt_next    = cnt_reg;
      busy_next   = busy_reg;
      done_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (Execute) begin
               state_next  = SHIFT;
               f_next      = F;
               r_next      = R;
               passes_next = Passes;
               cnt_next    = '0;
               busy_next   = 1'b1;
            end else begin
               if (LoadA) a_next = Din;
               if (LoadB) b_next = Din;
            end
         end
         SHIFT: begin
            a_next = {route_a, a_reg[WIDTH-1:1]};
            b_next = {route_b, b_reg[WIDTH-1:1]};
            if (last_shift) begin
               state_next = HOLD;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         HOLD: begin
            if (LoadA) a_next = Din;
            if (LoadB) b_next = Din;
            // Execute must drop before another operation can start.
            if (!Execute) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_reg  <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         f_reg      <= '0;
         r_reg      <= '0;
         passes_reg <= '0;
         cnt_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         f_reg      <= f_next;
         r_reg      <= r_next;
         passes_reg <= passes_next;
         cnt_reg    <= cnt_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
      end
   end

   assign A    = a_reg;
   assign B    = b_reg;
   assign Busy = busy_reg;
   assign Done = done_reg;

endmodule

// File: tb/tb_serial_logic_processor.sv
// Scoreboard bench: stimulus pushes word-level model results, negedge monitors
// pop and compare whenever Done pulses.
module tb_serial_logic_processor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   int vectors = 0;
   int errors = 0;

   logic       reset_n, load_a, load_b, execute;
   logic [7:0] din, a_out, b_out;
   logic [2:0] f_sel;
   logic [1:0] r_sel, passes;
   logic       busy, done;

   logic        load_a16, load_b16, execute16;
   logic [15:0] din16, a16, b16;
   logic [2:0]  passes16;
   logic        busy16, done16;

   serial_logic_processor #(.WIDTH(8), .PASS_W(2)) dut8 (
      .Clk(clk), .Reset(reset_n), .LoadA(load_a), .LoadB(load_b), .Execute(execute),
      .Din(din), .F(f_sel), .R(r_sel), .Passes(passes),
      .A(a_out), .B(b_out), .Busy(busy), .Done(done)
   );

   serial_logic_processor #(.WIDTH(16), .PASS_W(3)) dut16 (
      .Clk(clk), .Reset(reset_n), .LoadA(load_a16), .LoadB(load_b16), .Execute(execute16),
      .Din(din16), .F(f_sel), .R(r_sel), .Passes(passes16),
      .A(a16), .B(b16), .Busy(busy16), .Done(done16)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      int          n;
      int          cyc;
   } exp_t;

   exp_t q8[$];
   exp_t q16[$];
   exp_t m8, m16;
   int busy_cnt8 = 0;
   int busy_cnt16 = 0;

   logic [7:0]  ma, mb;
   logic [15:0] ma16, mb16;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Whole-word reference: every pass rewrites both registers with the routed words.
   function automatic logic [31:0] model_op(input logic [15:0] a_in, input logic [15:0] b_in,
                                            input logic [2:0] f, input logic [1:0] r,
                                            input int extra, input int w);
      logic [15:0] a, b, fw, mask, t;
      a = a_in;
      b = b_in;
      mask = 16'((32'd1 << w) - 32'd1);
      for (int p = 0; p <= extra; p++) begin
         case (f)
            3'd0: fw = a & b;
            3'd1: fw = a | b;
            3'd2: fw = a ^ b;
            3'd3: fw = 16'hFFFF;
            3'd4: fw = ~(a & b);
            3'd5: fw = ~(a | b);
            3'd6: fw = ~(a ^ b);
            default: fw = 16'h0000;
         endcase
         fw = fw & mask;
         case (r)
            2'd0: ;
            2'd1: b = fw;
            2'd2: a = fw;
            default: begin t = a; a = b; b = t; end
         endcase
      end
      return {a, b};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         busy_cnt8 = 0;
      end else begin
         if (busy) busy_cnt8++;
         if (done) begin
            if (q8.size() == 0) begin
               check("done8_unexpected", 32'(done), 32'd0);
            end else begin
               m8 = q8.pop_front();
               check("res8_a", 32'(a_out), 32'(m8.a));
               check("res8_b", 32'(b_out), 32'(m8.b));
               check("busy8_cycles", 32'(busy_cnt8), 32'(m8.n));
               check("done8_cycle", 32'(cyc), 32'(m8.cyc));
            end
            busy_cnt8 = 0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         busy_cnt16 = 0;
      end else begin
         if (busy16) busy_cnt16++;
         if (done16) begin
            if (q16.size() == 0) begin
               check("done16_unexpected", 32'(done16), 32'd0);
            end else begin
               m16 = q16.pop_front();
               check("res16_a", 32'(a16), 32'(m16.a));
               check("res16_b", 32'(b16), 32'(m16.b));
               check("busy16_cycles", 32'(busy_cnt16), 32'(m16.n));
               check("done16_cycle", 32'(cyc), 32'(m16.cyc));
            end
            busy_cnt16 = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load8(input logic [7:0] va, input logic [7:0] vb);
      load_a = 1'b1; din = va; tick();
      load_a = 1'b0; load_b = 1'b1; din = vb; tick();
      load_b = 1'b0;
      ma = va; mb = vb;
      check("load_a", 32'(a_out), 32'(ma));
      check("load_b", 32'(b_out), 32'(mb));
   endtask

   task automatic run8(input logic [2:0] f, input logic [1:0] r, input logic [1:0] p,
                       input int hold, input bit disturb, input bit idle_load);
      int n;
      logic [31:0] res;
      logic [7:0] oa, ob, hv;
      exp_t e;
      n = 8 * (int'(p) + 1);
      oa = ma; ob = mb;
      f_sel = f; r_sel = r; passes = p; execute = 1'b1;
      if (idle_load) begin
         load_a = 1'b1; load_b = 1'b1; din = 8'($urandom);
      end
      tick();
      load_a = 1'b0; load_b = 1'b0;
      res = model_op(16'(oa), 16'(ob), f, r, int'(p), 8);
      ma = res[23:16]; mb = res[7:0];
      e.a = 16'(ma); e.b = 16'(mb); e.n = n; e.cyc = cyc + n;
      q8.push_back(e);
      if (hold == 0) execute = 1'b0;
      for (int i = 1; i <= n; i++) begin
         if (disturb) begin
            f_sel = 3'($urandom); r_sel = 2'($urandom); passes = 2'($urandom);
            load_a = 1'($urandom); load_b = 1'($urandom); din = 8'hFF;
         end
         tick();
         if (i % 8 == 0 && i < n) begin
            res = model_op(16'(oa), 16'(ob), f, r, i / 8 - 1, 8);
            check("pass_a", 32'(a_out), 32'(res[23:16]));
            check("pass_b", 32'(b_out), 32'(res[7:0]));
         end
      end
      load_a = 1'b0; load_b = 1'b0;
      if (hold > 0) begin
         hv = 8'($urandom);
         din = hv; load_b = 1'b1; tick();
         load_b = 1'b0; mb = hv;
         check("hold_load_b", 32'(b_out), 32'(mb));
         repeat (hold) tick();
      end
      execute = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      $display("op8 f=%0d r=%0d passes=%0d hold=%0d disturb=%0d -> A=%02h B=%02h",
               f, r, p, hold, disturb, ma, mb);
   endtask

   initial begin
      exp_t e;
      logic [31:0] res;
      reset_n = 1'b0; load_a = 1'b0; load_b = 1'b0; execute = 1'b0; din = '0;
      f_sel = '0; r_sel = '0; passes = '0;
      load_a16 = 1'b0; load_b16 = 1'b0; execute16 = 1'b0; din16 = '0; passes16 = '0;
      ma = '0; mb = '0; ma16 = '0; mb16 = '0;
      tick(); tick();
      check("rst_a", 32'(a_out), 32'd0);
      check("rst_b", 32'(b_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_a16", 32'(a16), 32'd0);
      reset_n = 1'b1;
      tick();

      load_a = 1'b1; load_b = 1'b1; din = 8'h5A; tick();
      load_a = 1'b0; load_b = 1'b0;
      check("both_load_a", 32'(a_out), 32'h5A);
      check("both_load_b", 32'(b_out), 32'h5A);

      load8(8'h33, 8'h55);
      run8(3'b000, 2'b10, 2'd0, 0, 1'b0, 1'b0);
      check("and_route_a", 32'(a_out), 32'h11);
      load8(8'hA5, 8'h3C);
      run8(3'($urandom), 2'b11, 2'd0, 0, 1'b0, 1'b0);
      check("swap_a", 32'(a_out), 32'h3C);
      check("swap_b", 32'(b_out), 32'hA5);
      load8(8'h33, 8'h55);
      run8(3'b010, 2'b10, 2'd1, 0, 1'b0, 1'b0);
      check("xor2_a", 32'(a_out), 32'h33);
      load8(8'h33, 8'h55);
      run8(3'b010, 2'b10, 2'd1, 40, 1'b0, 1'b0);
      load8(8'h33, 8'h55);
      run8(3'b010, 2'b10, 2'd1, 0, 1'b1, 1'b0);
      load8(8'hC3, 8'h96);
      run8(3'b110, 2'b01, 2'd2, 0, 1'b0, 1'b1);

      // Abort mid-operation: four shifts, then reset.
      load8(8'h33, 8'h55);
      f_sel = 3'b000; r_sel = 2'b10; passes = 2'd0; execute = 1'b1;
      tick();
      execute = 1'b0;
      repeat (4) tick();
      reset_n = 1'b0; tick(); reset_n = 1'b1;
      check("abort_a", 32'(a_out), 32'd0);
      check("abort_b", 32'(b_out), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      ma = '0; mb = '0;
      load8(8'hA5, 8'h3C);
      run8(3'b001, 2'b11, 2'd0, 0, 1'b0, 1'b0);

      for (int k = 0; k < 25; k++) begin
         load8(8'($urandom), 8'($urandom));
         run8(3'($urandom), 2'($urandom), 2'($urandom),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0,
              1'($urandom), 1'($urandom));
      end

      // Wide instance, longest operation.
      load_a16 = 1'b1; din16 = 16'hF0F0; tick();
      load_a16 = 1'b0; load_b16 = 1'b1; din16 = 16'hFF00; tick();
      load_b16 = 1'b0;
      ma16 = 16'hF0F0; mb16 = 16'hFF00;
      f_sel = 3'b101; r_sel = 2'b01; passes16 = 3'd7; execute16 = 1'b1;
      tick();
      execute16 = 1'b0;
      res = model_op(ma16, mb16, 3'b101, 2'b01, 7, 16);
      e.a = res[31:16]; e.b = res[15:0]; e.n = 128; e.cyc = cyc + 128;
      q16.push_back(e);
      repeat (129) tick();
      check("w16_a", 32'(a16), 32'hF0F0);
      check("w16_b", 32'(b16), 32'h0F00);
      check("w16_busy", 32'(busy16), 32'd0);
      $display("op16 f=5 r=1 passes=7 -> A=%04h B=%04h", a16, b16);

      repeat (3) tick();
      check("q8_drain", 32'(q8.size()), 32'd0);
      check("q16_drain", 32'(q16.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/serial_logic_processor.md
# serial_logic_processor

Parametrised bit-serial logic processor: two WIDTH-bit operand registers A and B are loaded from a shared data input, then processed one bit per clock through a selectable logic function and a selectable routing network, with an optional multi-pass repeat. It is the next-generation datapath-plus-control core for the lab processor top level. Pushbutton synchronisation and hex display stay in the top level.

## Interface
- WIDTH, 8, operand width in bits (>= 2)
- PASS_W, 2, width of the Passes input; an operation runs Passes+1 passes
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low reset
- LoadA  in  1  active-high, already synchronised; load Din into A
- LoadB  in  1  active-high, already synchronised; load Din into B
- Execute  in  1  active-high level, already synchronised; starts an operation
- Din  in  WIDTH  load data
- F  in  3  function select
- R  in  2  routing select
- Passes  in  PASS_W  extra-pass count
- A  out  WIDTH  register A contents
- B  out  WIDTH  register B contents
- Busy  out  1  high while shifting
- Done  out  1  one-cycle pulse when an operation completes

## Operation
- F, per bit pair (a,b): 000 a&b, 001 a|b, 010 a^b, 011 1, 100 ~(a&b), 101 ~(a|b), 110 ~(a^b), 111 0.
- R, bits shifted into MSBs (f = function result): 00 A<-a, B<-b; 01 A<-a, B<-f; 10 A<-f, B<-b; 11 A<-b, B<-a.
- Each shift: a=A[0], b=B[0]; A and B shift right by one; routed bits enter A[WIDTH-1] and B[WIDTH-1].
- After WIDTH shifts, each register holds the bitwise routed result. Each further pass re-applies the operation to the updated registers.
- F, R and Passes are captured when the operation starts. Changes during SHIFT are ignored.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE: Execute=1 captures F/R/Passes, clears the shift counter and enters SHIFT. Otherwise LoadA/LoadB load Din.
  - SHIFT: one shift per cycle. The counter counts 0 to WIDTH*(Passes+1)-1. On the final shift the FSM enters HOLD.
  - HOLD: loads are accepted. Execute=0 returns the FSM to IDLE. Execute held high never retriggers.
- LoadA and LoadB asserted together: both registers take Din.
- Execute together with a load in IDLE: Execute wins and the loads are ignored that cycle.
- LoadA/LoadB during SHIFT: ignored.
- Shift counter must hold up to WIDTH*2^PASS_W - 1 without wrap.

## Timing
- Reset=0 at an edge: A=0, B=0, Busy=0, Done=0, state IDLE, counter 0. This takes priority over every other input, including mid-operation; the partial result is discarded.
- Load: a load sampled at edge k makes the new value visible on A/B after edge k.
- Let N = WIDTH*(Passes+1), and let Execute be sampled in IDLE at edge k.
  - Busy=1 from after edge k through edge k+N.
  - Shifts occur at edges k+1 through k+N.
  - Final result is visible after edge k+N.
  - Done=1 for exactly the cycle after edge k+N (state HOLD), then 0.
- Minimum period between operations: N+2 cycles, because Execute must be low for at least one edge in HOLD.
- Busy and Done are registered with no combinational path from the inputs.

## Test plan
- WIDTH=8, A=0x33, B=0x55, F=000, R=10, Passes=0, Execute one cycle -> A=0x11, B=0x55; Busy high 8 cycles; Done pulses once, 8 cycles after start.
- A=0xA5, B=0x3C, R=11, any F -> A=0x3C, B=0xA5.
- A=0x33, B=0x55, F=010, R=10, Passes=1 -> A=0x66 after 8 shifts, A=0x33 after 16; Done only at 16. Also: Execute held high 40 cycles -> exactly one operation; Done once.
- During SHIFT, toggle F, R and pulse LoadA with Din=0xFF -> result identical to the undisturbed run; A not loaded.
- Reset low after 4 shifts -> next cycle A=0, B=0, Busy=0, IDLE. A new load/execute then completes normally.
- WIDTH=16, PASS_W=3, A=0xF0F0, B=0xFF00, F=101, R=01, Passes=7 -> completion at 128 shifts; counter does not wrap. Final B: pass 1 gives 0x000F, pass 2 gives 0x0F00, alternating; after 8 passes B=0x0F00, A=0xF0F0.
